// File: rtl/graph_result_capture.sv
// graph_result_capture
// Samples the four result bits {q4,q3,q2,q1} on enabled edges and logs a
// timestamped entry into a small FIFO whenever the vector changes. The first
// enabled edge after reset or clear is always logged. When the FIFO is full
// and nothing is popped, the entry is dropped, a sticky overflow flag is set
// and a saturating drop counter is bumped. The producer side never stalls.
module graph_result_capture #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     q1,
    input  logic                     q2,
    input  logic                     q3,
    input  logic                     q4,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W+3:0]          out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [3:0]      cur;
    logic [TS_W-1:0] ts;
    logic [3:0]      prev;
    logic            first;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [TS_W+3:0] mem [DEPTH];

    logic empty;
    logic full;
    logic push_req;
    logic pop;
    logic push;
    logic drop;

    assign cur       = {q4, q3, q2, q1};
    assign level     = wr_ptr - rd_ptr;
    assign empty     = (level == '0);
    assign full      = (level == FULL_LVL);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Push/pop/drop decisions; a full FIFO still accepts a push when the head leaves.
    always_comb begin
        push_req = en && (first || (cur != prev));
        pop      = !empty && out_ready;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Sampler state, FIFO pointers and overflow bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts       <= '0;
            prev     <= '0;
            first    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            ts       <= '0;
            prev     <= '0;
            first    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (en) begin
                ts    <= ts + 1'b1;
                prev  <= cur;
                first <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Entry storage; a write under clr is harmless because the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ts, cur};
        end
    end

endmodule

// File: tb/tb_graph_result_capture.sv
// tb_graph_result_capture
// Directed stimulus with a reference model: every entry the model expects to be
// logged goes into a queue, and each cycle the DUT head is compared with the
// queue front; a pop on the DUT pops the queue.
module tb_graph_result_capture;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;

    logic            clk;
    logic            rst;
    logic            clr;
    logic            en;
    logic            q1, q2, q3, q4;
    logic            out_valid;
    logic            out_ready;
    logic [TS_W+3:0] out_data;
    logic [2:0]      level;
    logic            overflow;
    logic [7:0]      drop_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [TS_W+3:0] sbq[$];
    logic [TS_W-1:0] m_ts;
    logic [3:0]      m_prev;
    logic            m_first;
    logic            m_ovf;
    logic [7:0]      m_drop;

    graph_result_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (en),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3),
        .q4        (q4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sbq.delete();
        m_ts    = '0;
        m_prev  = '0;
        m_first = 1'b1;
        m_ovf   = 1'b0;
        m_drop  = '0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_level"}, 32'(level), 32'(sbq.size()));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock cycle: drive, compare head before the edge, update model, compare after.
    task automatic step(input string tag, input logic s_en, input logic [3:0] s_cur,
                        input logic s_ready, input logic s_clr);
        logic            do_pop;
        logic            do_req;
        logic [TS_W+3:0] entry;
        int              sz;
        en        = s_en;
        {q4, q3, q2, q1} = s_cur;
        out_ready = s_ready;
        clr       = s_clr;
        #1;
        sz = sbq.size();
        if (sz > 0) begin
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_head"}, 32'(out_data), 32'(sbq[0]));
        end else begin
            check({tag, "_valid0"}, 32'(out_valid), 32'd0);
            check({tag, "_data0"}, 32'(out_data), 32'd0);
        end
        if (s_clr) begin
            model_clear();
        end else begin
            do_pop = (sz > 0) && s_ready;
            do_req = s_en && (m_first || (s_cur != m_prev));
            entry  = {m_ts, s_cur};
            if (do_pop) void'(sbq.pop_front());
            if (do_req) begin
                if (sz < DEPTH || do_pop) begin
                    sbq.push_back(entry);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
            end
            if (s_en) begin
                m_ts    = m_ts + 1'b1;
                m_prev  = s_cur;
                m_first = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_flags(tag);
    endtask

    task automatic async_reset(input string tag);
        #1;
        rst = 1'b0;
        #2;
        model_clear();
        check({tag, "_rvalid"}, 32'(out_valid), 32'd0);
        check({tag, "_rdata"}, 32'(out_data), 32'd0);
        check_flags(tag);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        en  = 1'b0;
        {q4, q3, q2, q1} = 4'h0;
        out_ready = 1'b0;
        model_clear();
        #3;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check_flags("reset");
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // constant zero vector: a single entry at ts=0
        for (int i = 0; i < 5; i++) step("const", 1'b1, 4'h0, 1'b0, 1'b0);
        check("const_level1", 32'(level), 32'd1);
        check("const_head", 32'(out_data), 32'h000);
        drain("const_drain", 2);

        // change detection
        step("clr1", 1'b0, 4'h0, 1'b0, 1'b1);
        step("seq", 1'b1, 4'b0001, 1'b0, 1'b0);
        step("seq", 1'b1, 4'b0001, 1'b0, 1'b0);
        step("seq", 1'b1, 4'b0011, 1'b0, 1'b0);
        step("seq", 1'b1, 4'b0011, 1'b0, 1'b0);
        step("seq", 1'b1, 4'b1000, 1'b0, 1'b0);
        check("seq_level3", 32'(level), 32'd3);
        drain("seq_drain", 4);

        // overflow: 6 changes into DEPTH=4
        step("clr2", 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) step("ovf", 1'b1, 4'(i), 1'b0, 1'b0);
        check("ovf_level4", 32'(level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_cnt2", 32'(drop_cnt), 32'd2);
        drain("ovf_drain", 5);

        // full with simultaneous push and pop
        step("clr3", 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step("full", 1'b1, 4'(i), 1'b0, 1'b0);
        step("fullpp", 1'b1, 4'h5, 1'b1, 1'b0);
        check("fullpp_level", 32'(level), 32'd4);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        check("fullpp_head", 32'(out_data), {20'd0, 8'd1, 4'h2});
        drain("full_drain", 5);

        // enable gating of sampling and timestamp
        step("clr4", 1'b0, 4'h0, 1'b0, 1'b1);
        step("engate", 1'b1, 4'h1, 1'b0, 1'b0);
        step("engate", 1'b0, 4'h2, 1'b0, 1'b0);
        step("engate", 1'b0, 4'h3, 1'b0, 1'b0);
        step("engate", 1'b1, 4'h4, 1'b0, 1'b0);
        check("engate_level", 32'(level), 32'd2);
        drain("engate_drain", 3);

        // async reset mid-drain, then first edge logs ts=0 even if cur==old prev
        for (int i = 1; i <= 4; i++) step("rfill", 1'b1, 4'(i + 8), 1'b0, 1'b0);
        step("rdrain", 1'b0, 4'h0, 1'b1, 1'b0);
        check("rmid_level3", 32'(level), 32'd3);
        async_reset("rmid");
        step("rpost", 1'b1, 4'h0, 1'b0, 1'b0);
        check("rpost_head", 32'(out_data), 32'h000);
        step("rpost", 1'b1, 4'h0, 1'b0, 1'b0);
        drain("rpost_drain", 2);

        // clr mid-drain with overflow set
        for (int i = 1; i <= 6; i++) step("cfill", 1'b1, 4'(i + 3), 1'b0, 1'b0);
        step("cdrain", 1'b0, 4'h0, 1'b1, 1'b0);
        step("cclr", 1'b1, 4'h7, 1'b1, 1'b1);
        check("cclr_valid", 32'(out_valid), 32'd0);
        step("cpost", 1'b1, 4'h9, 1'b0, 1'b0);
        check("cpost_head", 32'(out_data), 32'h009);
        drain("cpost_drain", 2);

        // drop counter saturation and timestamp wrap
        step("clr5", 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 264; i++) step("sat", 1'b1, (i % 2) ? 4'h5 : 4'hA, 1'b0, 1'b0);
        check("sat_cnt", 32'(drop_cnt), 32'd255);
        drain("sat_drain", 4);
        step("wrap", 1'b1, 4'h3, 1'b0, 1'b0);
        check("wrap_head", 32'(out_data), {20'd0, 8'd8, 4'h3});
        drain("wrap_drain", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
